// File: rtl/vga_pixel_sink.sv
// 160x120 3-bit framebuffer with a plot write port, a registered scan-out read
// port and a hardware clear engine that sweeps BG_COLOUR over every pixel.
module vga_pixel_sink #(
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
  input  logic        clear,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic [2:0]  rd_colour,
  output logic        busy,
  output logic [15:0] plot_count,
  output logic [15:0] drop_count
);

  localparam int          DEPTH     = 160 * 120;
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic [15:0] plot_cnt_q, plot_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [2:0]  rd_colour_q, rd_colour_d;

  logic [2:0]  mem [0:DEPTH-1];

  logic        wr_in_range, rd_in_range;
  logic [14:0] wr_addr, rd_addr;
  logic        plot_accept, plot_reject;
  logic        mem_we;
  logic [14:0] mem_wa;
  logic [2:0]  mem_wd;

  // y*160 + x as (y<<7) + (y<<5) + x; the largest legal address is 19199
  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    return {1'b0, py, 7'b0} + {3'b0, py, 5'b0} + {7'b0, px};
  endfunction

  always_comb begin
    wr_in_range = (x < 8'd160) && (y < 7'd120);
    rd_in_range = (rd_x < 8'd160) && (rd_y < 7'd120);
    wr_addr     = pix_addr(x, y);
    rd_addr     = pix_addr(rd_x, rd_y);
  end

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear) state_d = S_CLEAR;
      S_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs of the FSM: write port steering and plot disposition
  always_comb begin
    busy        = (state_q == S_CLEAR);
    plot_accept = 1'b0;
    plot_reject = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = wr_addr;
    mem_wd      = colour;
    case (state_q)
      S_IDLE: begin
        // clear wins over a simultaneous plot, which is then counted as dropped
        plot_accept = plot && !clear && wr_in_range;
        plot_reject = plot && !plot_accept;
        mem_we      = plot_accept && !reset;
      end
      S_CLEAR: begin
        plot_reject = plot;
        mem_we      = !reset;
        mem_wa      = clr_addr_q;
        mem_wd      = BG_COLOUR;
      end
      default: ;
    endcase
  end

  always_comb begin
    clr_addr_d = clr_addr_q;
    if (state_q == S_CLEAR)
      clr_addr_d = (clr_addr_q == LAST_ADDR) ? 15'd0 : clr_addr_q + 15'd1;
    else if (clear)
      clr_addr_d = 15'd0;

    plot_cnt_d = plot_cnt_q;
    if (plot_accept && plot_cnt_q != 16'hFFFF) plot_cnt_d = plot_cnt_q + 16'd1;
    drop_cnt_d = drop_cnt_q;
    if (plot_reject && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

    // mem is read before this edge's write lands, giving read-before-write
    rd_colour_d = rd_in_range ? mem[rd_addr] : 3'b000;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clr_addr_q  <= 15'd0;
      plot_cnt_q  <= 16'd0;
      drop_cnt_q  <= 16'd0;
      rd_colour_q <= 3'b000;
    end else begin
      clr_addr_q  <= clr_addr_d;
      plot_cnt_q  <= plot_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_colour_q <= rd_colour_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rd_colour  = rd_colour_q;
  assign plot_count = plot_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Randomized and directed checks of vga_pixel_sink against a pixel-array model.
module tb_vga_pixel_sink;

  localparam logic [2:0] BG = 3'b000;

  logic        CLOCK_50 = 1'b0;
  logic        reset, plot, clear;
  logic [7:0]  x, rd_x;
  logic [6:0]  y, rd_y;
  logic [2:0]  colour, rd_colour;
  logic        busy;
  logic [15:0] plot_count, drop_count;

  vga_pixel_sink #(.BG_COLOUR(BG)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .x(x), .y(y), .colour(colour),
    .plot(plot), .clear(clear), .rd_x(rd_x), .rd_y(rd_y),
    .rd_colour(rd_colour), .busy(busy), .plot_count(plot_count), .drop_count(drop_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // model: -1 marks a pixel whose contents are not yet known
  int  mem_m [19200];
  int  pc_m, dc_m, clr_left;
  int  tests, fails;
  bit  chk;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: predict from the rules, advance, compare
  task automatic cycle();
    int exp_rd;
    exp_rd = (rd_x < 160 && rd_y < 120) ? mem_m[rd_y * 160 + rd_x] : 0;
    if (reset) begin
      pc_m = 0; dc_m = 0; clr_left = 19200; exp_rd = 0;
    end else if (clr_left > 0) begin
      if (plot) dc_m = sat(dc_m);
      mem_m[19200 - clr_left] = BG;
      clr_left--;
    end else if (clear) begin
      if (plot) dc_m = sat(dc_m);
      clr_left = 19200;
    end else if (plot) begin
      if (x < 160 && y < 120) begin
        mem_m[y * 160 + x] = colour;
        pc_m = sat(pc_m);
      end else dc_m = sat(dc_m);
    end
    @(posedge CLOCK_50); #1;
    if (chk) begin
      chk_eq("busy", {31'd0, busy}, {31'd0, clr_left > 0});
      chk_eq("plot_count", {16'd0, plot_count}, pc_m);
      chk_eq("drop_count", {16'd0, drop_count}, dc_m);
      if (exp_rd >= 0) chk_eq("rd_colour", {29'd0, rd_colour}, exp_rd);
    end
  endtask

  task automatic set_plot(input bit p, input int px, input int py, input int c);
    plot = p; x = 8'(px); y = 7'(py); colour = 3'(c);
  endtask

  task automatic set_rd(input int px, input int py);
    rd_x = 8'(px); rd_y = 7'(py);
  endtask

  initial begin
    int n, dc0, pc0;
    tests = 0; fails = 0; chk = 1'b1;
    pc_m = 0; dc_m = 0; clr_left = 0;
    foreach (mem_m[i]) mem_m[i] = -1;
    reset = 1'b1; clear = 1'b0;
    set_plot(1'b1, 1, 1, 7); set_rd(0, 0);

    // reset state (plot held high must not be counted)
    cycle();
    chk_eq("rst_busy", {31'd0, busy}, 32'd1);
    chk_eq("rst_pc", {16'd0, plot_count}, 32'd0);
    chk_eq("rst_rd", {29'd0, rd_colour}, 32'd0);

    // clear started by reset; plots during it are drops; reset again at cycle 5000
    reset = 1'b0;
    for (int i = 0; i < 4999; i++) begin
      set_plot($urandom_range(0, 1), $urandom_range(0, 200), $urandom_range(0, 127), $urandom);
      set_rd($urandom_range(0, 170), $urandom_range(0, 125));
      cycle();
    end
    reset = 1'b1; set_plot(1'b1, 2, 2, 5);
    cycle();
    chk_eq("midrst_dc", {16'd0, drop_count}, 32'd0);
    reset = 1'b0; set_plot(1'b0, 0, 0, 0);
    n = 0;
    while (busy === 1'b1 && n < 25000) begin
      cycle(); n++;
    end
    chk_eq("clear_len", n, 32'd19200);
    chk_eq("post_pc", {16'd0, plot_count}, 32'd0);
    chk_eq("post_dc", {16'd0, drop_count}, 32'd0);

    set_rd(0, 0); cycle();
    chk_eq("rd_0_0", {29'd0, rd_colour}, {29'd0, BG});
    set_rd(159, 119); cycle();
    chk_eq("rd_159_119", {29'd0, rd_colour}, {29'd0, BG});

    // single plot, then read it back
    set_plot(1'b1, 5, 3, 3'b101); set_rd(200, 0); cycle();
    chk_eq("oor_rd", {29'd0, rd_colour}, 32'd0);
    set_plot(1'b0, 0, 0, 0); set_rd(5, 3); cycle();
    chk_eq("rd_5_3", {29'd0, rd_colour}, 32'b101);
    chk_eq("pc_1", {16'd0, plot_count}, 32'd1);

    // out-of-range plots
    pc0 = plot_count; dc0 = drop_count;
    set_plot(1'b1, 160, 0, 7); cycle();
    set_plot(1'b1, 0, 120, 7); set_rd(0, 0); cycle();
    set_plot(1'b0, 0, 0, 0); cycle();
    chk_eq("oor_mem", {29'd0, rd_colour}, {29'd0, BG});
    chk_eq("oor_dc", {16'd0, drop_count}, dc0 + 2);
    chk_eq("oor_pc", {16'd0, plot_count}, pc0);

    // read-before-write at the same address
    set_plot(1'b1, 40, 40, 6); set_rd(40, 40); cycle();
    set_plot(1'b1, 40, 40, 1); cycle();
    chk_eq("rbw", {29'd0, rd_colour}, 32'd6);

    // random traffic; reads often aim at the pixel being written
    set_plot(1'b0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      set_plot($urandom_range(0, 3) != 0, $urandom_range(0, 175), $urandom_range(0, 127), $urandom);
      if ($urandom_range(0, 1)) set_rd(x, y);
      else set_rd($urandom_range(0, 165), $urandom_range(0, 124));
      cycle();
    end

    // drive plot_count to saturation
    chk = 1'b0;
    while (pc_m < 65534) begin
      set_plot(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom);
      cycle();
    end
    chk = 1'b1;
    set_plot(1'b0, 0, 0, 0); cycle();
    chk_eq("pc_fffe", {16'd0, plot_count}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      set_plot(1'b1, 7 + i, 9, 2); cycle();
    end
    chk_eq("pc_sat", {16'd0, plot_count}, 32'hFFFF);

    // clear and plot together: clear wins, plot is dropped
    dc0 = drop_count;
    clear = 1'b1; set_plot(1'b1, 10, 10, 7); cycle();
    chk_eq("clr_busy", {31'd0, busy}, 32'd1);
    chk_eq("clr_drop", {16'd0, drop_count}, dc0 + 1);
    clear = 1'b0; set_plot(1'b0, 0, 0, 0); set_rd(10, 10);
    for (int i = 0; i < 1700; i++) begin
      clear = (i == 100);
      cycle();
    end
    chk_eq("rd_10_10_bg", {29'd0, rd_colour}, {29'd0, BG});
    chk_eq("still_busy", {31'd0, busy}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
